// File: rtl/vga_timing_decoder.sv
// -----------------------------------------------------------------------------
// vga_timing_decoder
//
// Receiving end of the in-house VGA sync interface. Follows an externally
// generated h_sync/v_sync stream (both active-high), recovers the pixel
// position and a display-area flag, measures line period and lines per frame,
// and declares lock once the measured timing matches the configured format
// for LOCK_FRAMES consecutive frames.
//
// Ports:
//   clk             in   pixel clock
//   reset           in   asynchronous, active-high reset
//   h_sync          in   horizontal sync, active-high, synchronous to clk
//   v_sync          in   vertical sync, active-high, synchronous to clk
//   pos_x[9:0]      out  recovered column
//   pos_y[9:0]      out  recovered line
//   in_display_area out  locked & pos_x < H_ACTIVE & pos_y < V_ACTIVE
//   line_len[10:0]  out  last measured h_sync rise-to-rise period in clocks
//   frame_lines[10:0] out last measured h_sync rises per v_sync period
//   locked          out  timing matches the parameters
//   sync_error      out  one-cycle pulse on a timing violation
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module vga_timing_decoder #(
    parameter int H_TOTAL     = 801,
    parameter int V_TOTAL     = 526,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_EDGE_X    = 658,
    parameter int V_EDGE_Y    = 491,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        in_display_area,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic        locked,
    output logic        sync_error
);

    localparam logic [9:0]  H_LAST_C     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST_C     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACTIVE_C   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACTIVE_C   = 10'(V_ACTIVE);
    localparam logic [9:0]  H_EDGE_C     = 10'(H_EDGE_X);
    localparam logic [9:0]  V_EDGE_C     = 10'(V_EDGE_Y);
    localparam logic [10:0] H_TOTAL_C    = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_C    = 11'(V_TOTAL);
    localparam logic [10:0] CNT_MAX_C    = 11'h7FF;
    localparam logic [10:0] CNT_PRE_MAX_C = 11'h7FE;
    localparam logic [7:0]  LOCK_C       = 8'(LOCK_FRAMES);

    // Increment with wrap to zero once the last legal value is reached.
    function automatic logic [9:0] wrap_inc(input logic [9:0] value, input logic [9:0] last);
        if (value >= last) begin
            return 10'd0;
        end else begin
            return value + 10'd1;
        end
    endfunction

    // State registers
    logic        h_sync_d_r, v_sync_d_r;
    logic [9:0]  pos_x_r, pos_y_r;
    logic        in_disp_r;
    logic [10:0] h_cnt_r, line_cnt_r;
    logic [10:0] line_len_r, frame_lines_r;
    logic        h_seen_r, v_seen_r, frame_bad_r;
    logic [7:0]  good_cnt_r;
    logic        locked_r, sync_error_r;

    // Next-state values
    logic [9:0]  pos_x_s, pos_y_s;
    logic        in_disp_s;
    logic [10:0] h_cnt_s, line_cnt_s, line_len_s, frame_lines_s;
    logic        h_seen_s, v_seen_s, frame_bad_s;
    logic [7:0]  good_cnt_s;
    logic        locked_s;

    // Edge and error detection
    logic h_rise_s, v_rise_s;
    logic line_err_s, frame_err_s, timeout_s, any_err_s;

    assign h_rise_s = h_sync & ~h_sync_d_r;
    assign v_rise_s = v_sync & ~v_sync_d_r;

    // Period checks only once a previous rise has given a valid reference.
    assign line_err_s  = h_rise_s & h_seen_r & (h_cnt_r != H_TOTAL_C);
    assign frame_err_s = v_rise_s & v_seen_r & (line_cnt_r != V_TOTAL_C);
    // Fires on the step into saturation, so a long stall reports only once;
    // h_seen drops at the same time so the resuming rise is not compared.
    assign timeout_s   = h_seen_r & ~h_rise_s & (h_cnt_r == CNT_PRE_MAX_C);
    assign any_err_s   = line_err_s | frame_err_s | timeout_s;

    // Position recovery: reload on sync edges, free-run in between.
    always_comb begin
        pos_x_s = pos_x_r;
        pos_y_s = pos_y_r;
        if (h_rise_s) begin
            pos_x_s = H_EDGE_C;
        end else begin
            pos_x_s = wrap_inc(pos_x_r, H_LAST_C);
        end
        // Vertical reload beats the line-wrap increment; a wrap coinciding
        // with h_rise is suppressed because the reload redefines the line.
        if (v_rise_s) begin
            pos_y_s = V_EDGE_C;
        end else if (!h_rise_s && (pos_x_r >= H_LAST_C)) begin
            pos_y_s = wrap_inc(pos_y_r, V_LAST_C);
        end else begin
            pos_y_s = pos_y_r;
        end
    end

    // Period measurement, validity flags and lock qualification.
    always_comb begin
        h_cnt_s       = h_cnt_r;
        line_cnt_s    = line_cnt_r;
        line_len_s    = line_len_r;
        frame_lines_s = frame_lines_r;
        h_seen_s      = h_seen_r;
        v_seen_s      = v_seen_r;
        frame_bad_s   = frame_bad_r;
        good_cnt_s    = good_cnt_r;
        locked_s      = locked_r;
        in_disp_s     = 1'b0;

        if (h_rise_s) begin
            line_len_s = h_cnt_r;
            h_cnt_s    = 11'd1;
        end else if (h_cnt_r != CNT_MAX_C) begin
            h_cnt_s = h_cnt_r + 11'd1;
        end else begin
            h_cnt_s = h_cnt_r;
        end

        // A rise coinciding with v_rise is the first line of the new frame.
        if (v_rise_s) begin
            frame_lines_s = line_cnt_r;
            line_cnt_s    = {10'd0, h_rise_s};
        end else if (h_rise_s && (line_cnt_r != CNT_MAX_C)) begin
            line_cnt_s = line_cnt_r + 11'd1;
        end else begin
            line_cnt_s = line_cnt_r;
        end

        if (h_rise_s) begin
            h_seen_s = 1'b1;
        end else if (timeout_s) begin
            h_seen_s = 1'b0;
        end else begin
            h_seen_s = h_seen_r;
        end

        if (v_rise_s) begin
            v_seen_s = 1'b1;
        end else begin
            v_seen_s = v_seen_r;
        end

        // An error on the v_rise cycle is charged to the frame that is
        // closing (good_cnt already zeroes), so the new frame starts clean.
        if (v_rise_s) begin
            frame_bad_s = 1'b0;
        end else if (any_err_s) begin
            frame_bad_s = 1'b1;
        end else begin
            frame_bad_s = frame_bad_r;
        end

        if (any_err_s) begin
            good_cnt_s = 8'd0;
        end else if (v_rise_s && v_seen_r && !frame_bad_r && (good_cnt_r < LOCK_C)) begin
            good_cnt_s = good_cnt_r + 8'd1;
        end else begin
            good_cnt_s = good_cnt_r;
        end

        if (any_err_s) begin
            locked_s = 1'b0;
        end else if (good_cnt_s == LOCK_C) begin
            locked_s = 1'b1;
        end else begin
            locked_s = locked_r;
        end

        // Computed from next-state values so it lines up with pos_x/pos_y.
        in_disp_s = locked_s & (pos_x_s < H_ACTIVE_C) & (pos_y_s < V_ACTIVE_C);
    end

    // State register; sync delay lines reset high so a held sync is no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_sync_d_r    <= 1'b1;
            v_sync_d_r    <= 1'b1;
            pos_x_r       <= 10'd0;
            pos_y_r       <= 10'd0;
            in_disp_r     <= 1'b0;
            h_cnt_r       <= 11'd0;
            line_cnt_r    <= 11'd0;
            line_len_r    <= 11'd0;
            frame_lines_r <= 11'd0;
            h_seen_r      <= 1'b0;
            v_seen_r      <= 1'b0;
            frame_bad_r   <= 1'b0;
            good_cnt_r    <= 8'd0;
            locked_r      <= 1'b0;
            sync_error_r  <= 1'b0;
        end else begin
            h_sync_d_r    <= h_sync;
            v_sync_d_r    <= v_sync;
            pos_x_r       <= pos_x_s;
            pos_y_r       <= pos_y_s;
            in_disp_r     <= in_disp_s;
            h_cnt_r       <= h_cnt_s;
            line_cnt_r    <= line_cnt_s;
            line_len_r    <= line_len_s;
            frame_lines_r <= frame_lines_s;
            h_seen_r      <= h_seen_s;
            v_seen_r      <= v_seen_s;
            frame_bad_r   <= frame_bad_s;
            good_cnt_r    <= good_cnt_s;
            locked_r      <= locked_s;
            sync_error_r  <= any_err_s;
        end
    end

    assign pos_x           = pos_x_r;
    assign pos_y           = pos_y_r;
    assign in_display_area = in_disp_r;
    assign line_len        = line_len_r;
    assign frame_lines     = frame_lines_r;
    assign locked          = locked_r;
    assign sync_error      = sync_error_r;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for vga_timing_decoder, using a scaled-down
// format (40-clock lines, 12-line frames) so several frames fit in a short run.
// -----------------------------------------------------------------------------
module tb_vga_timing_decoder;

    localparam int HT = 40, VT = 12, HA = 24, VA = 8, HEX = 28, VEY = 9, LF = 2;
    localparam int H_PW = 4, V_PW = 2, SHORT_LINE = 3, SHORT_LEN = 30, V_OFF_NOM = 10;

    localparam logic [9:0]  X_EDGE    = 10'd28;
    localparam logic [9:0]  Y_EDGE    = 10'd9;
    localparam logic [10:0] LEN_NOM   = 11'd40;
    localparam logic [10:0] LEN_SHORT = 11'd30;
    localparam logic [10:0] LINES_NOM = 11'd12;
    localparam int          DISP_EXP  = 192;   // 24 columns x 8 lines

    logic        clk, reset, h_sync, v_sync;
    logic [9:0]  pos_x, pos_y;
    logic        in_display_area, locked, sync_error;
    logic [10:0] line_len, frame_lines;

    int errors = 0;
    int checks = 0;

    // Sync stream generator state
    int   gen_col, gen_line, v_off, since_h;
    bit   gen_en, short_req, short_end, h_rise_drv, v_rise_drv;
    logic h_prev, v_prev;

    vga_timing_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_EDGE_X(HEX), .V_EDGE_Y(VEY), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
        .pos_x(pos_x), .pos_y(pos_y), .in_display_area(in_display_area),
        .line_len(line_len), .frame_lines(frame_lines),
        .locked(locked), .sync_error(sync_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one generator sample, clock it in, and return 1 time unit later.
    task automatic cycle();
        logic h, v;
        int   idx;
        if (gen_en) begin
            idx = gen_line * HT + gen_col;
            h   = (gen_col < H_PW);
            v   = (idx >= v_off) && (idx < v_off + V_PW * HT);
        end else begin
            h = 1'b0;
            v = 1'b0;
        end
        h_rise_drv = h & ~h_prev;
        v_rise_drv = v & ~v_prev;
        h_prev = h;
        v_prev = v;
        h_sync = h;
        v_sync = v;
        if (gen_en) begin
            gen_col++;
            if ((short_req && gen_line == SHORT_LINE && gen_col == SHORT_LEN) || gen_col == HT) begin
                if (short_req && gen_line == SHORT_LINE && gen_col == SHORT_LEN) begin
                    short_req = 1'b0;
                    short_end = 1'b1;
                end
                gen_col  = 0;
                gen_line = (gen_line == VT - 1) ? 0 : gen_line + 1;
            end
        end
        @(posedge clk);
        #1;
        if (h_rise_drv) since_h = 0;
        else since_h++;
    endtask

    task automatic restart_gen(input int off);
        gen_col  = 0;
        gen_line = 0;
        v_off    = off;
        gen_en   = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
        h_prev = 1'b1; v_prev = 1'b1; gen_en = 1'b0;
        short_req = 1'b0; short_end = 1'b0; since_h = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pos_x, pos_y, in_display_area, line_len, frame_lines, locked, sync_error} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: got x=%0d y=%0d len=%0d lines=%0d lock=%0d err=%0d required all 0",
                     pos_x, pos_y, line_len, frame_lines, locked, sync_error);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({in_display_area, line_len, frame_lines, locked, sync_error} !== 25'd0) begin
                errors++;
                $display("FAIL held_sync_quiet: cycle %0d got len=%0d lines=%0d lock=%0d err=%0d disp=%0d required 0",
                         i, line_len, frame_lines, locked, sync_error, in_display_area);
            end
        end
        // No edge seen: pos_x simply free-ran 20 steps from 0.
        checks++;
        if (pos_x !== 10'd20) begin
            errors++; $display("FAIL held_sync_pos_x: got %0d required 20", pos_x);
        end
        checks++;
        if (pos_y !== 10'd0) begin
            errors++; $display("FAIL held_sync_pos_y: got %0d required 0", pos_y);
        end
    endtask

    task automatic test_nominal();
        int hr = 0, vr = 0, pulses = 0, disp = 0;
        gen_en = 1'b0;
        repeat (3) cycle();
        restart_gen(V_OFF_NOM);
        for (int i = 0; i < 3000 && vr < 4; i++) begin
            cycle();
            if (sync_error) pulses++;
            if (h_rise_drv) begin
                hr++;
                checks++;
                if (pos_x !== X_EDGE) begin
                    errors++; $display("FAIL nom_pos_x_reload: rise %0d got %0d required %0d", hr, pos_x, X_EDGE);
                end
                if (hr >= 2) begin
                    checks++;
                    if (line_len !== LEN_NOM) begin
                        errors++; $display("FAIL nom_line_len: rise %0d got %0d required %0d", hr, line_len, LEN_NOM);
                    end
                end
            end
            if (v_rise_drv) begin
                vr++;
                if (vr >= 2) begin
                    checks++;
                    if (frame_lines !== LINES_NOM) begin
                        errors++; $display("FAIL nom_frame_lines: vrise %0d got %0d required %0d", vr, frame_lines, LINES_NOM);
                    end
                end
                checks++;
                if (locked !== (vr >= 3)) begin
                    errors++; $display("FAIL nom_lock: vrise %0d got %0d required %0d", vr, locked, (vr >= 3));
                end
            end
            if ((vr == 3 && !v_rise_drv) || (vr == 4 && v_rise_drv)) begin
                if (in_display_area) disp++;
            end
        end
        checks++;
        if (vr != 4) begin
            errors++; $display("FAIL nom_timeout: got %0d v_rises required 4", vr);
        end
        checks++;
        if (disp != DISP_EXP) begin
            errors++; $display("FAIL nom_display_count: got %0d required %0d", disp, DISP_EXP);
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL nom_no_error: got %0d pulses required 0", pulses);
        end
    endtask

    task automatic test_short_line();
        int vr = 0, pulses = 0;
        bit seen_bad = 1'b0;
        short_req = 1'b1;
        short_end = 1'b0;
        for (int i = 0; i < 3000 && vr < 3; i++) begin
            cycle();
            if (sync_error) pulses++;
            if (h_rise_drv && short_end) begin
                short_end = 1'b0;
                seen_bad  = 1'b1;
                checks++;
                if (sync_error !== 1'b1) begin
                    errors++; $display("FAIL short_err_pulse: got %0d required 1", sync_error);
                end
                checks++;
                if (line_len !== LEN_SHORT) begin
                    errors++; $display("FAIL short_line_len: got %0d required %0d", line_len, LEN_SHORT);
                end
                checks++;
                if (locked !== 1'b0) begin
                    errors++; $display("FAIL short_unlock: got %0d required 0", locked);
                end
                cycle();
                checks++;
                if (sync_error !== 1'b0) begin
                    errors++; $display("FAIL short_err_one_cycle: got %0d required 0", sync_error);
                end
            end
            if (v_rise_drv && seen_bad) begin
                vr++;
                checks++;
                if (locked !== (vr == 3)) begin
                    errors++; $display("FAIL short_relock: vrise %0d got %0d required %0d", vr, locked, (vr == 3));
                end
            end
        end
        checks++;
        if (!seen_bad || vr != 3) begin
            errors++; $display("FAIL short_timeout: got bad=%0d vrises=%0d required 1 and 3", seen_bad, vr);
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL short_pulse_count: got %0d required 1", pulses);
        end
    endtask

    task automatic test_timeout();
        int vr = 0, pulses = 0, extra = 0;
        bit got = 1'b0;
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL stall_precondition_lock: got %0d required 1", locked);
        end
        for (int i = 0; i < 1000 && !(gen_line == 5 && gen_col == 20); i++) cycle();
        gen_en = 1'b0;
        for (int i = 0; i < 2200 && !got; i++) begin
            cycle();
            if (sync_error) begin
                got = 1'b1;
                checks++;
                if (since_h != 2046) begin
                    errors++; $display("FAIL stall_err_time: got %0d cycles after rise required 2046", since_h);
                end
                checks++;
                if (locked !== 1'b0) begin
                    errors++; $display("FAIL stall_unlock: got %0d required 0", locked);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL stall_no_error: got 0 pulses required 1");
        end
        repeat (40) begin
            cycle();
            if (sync_error) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL stall_single_pulse: got %0d extra pulses required 0", extra);
        end
        checks++;
        if (line_len !== LEN_NOM) begin
            errors++; $display("FAIL stall_line_len_hold: got %0d required %0d", line_len, LEN_NOM);
        end
        gen_en = 1'b1;
        for (int i = 0; i < 3000 && vr < 3; i++) begin
            cycle();
            if (sync_error) pulses++;
            if (v_rise_drv) begin
                vr++;
                checks++;
                if (locked !== (vr == 3)) begin
                    errors++; $display("FAIL stall_relock: vrise %0d got %0d required %0d", vr, locked, (vr == 3));
                end
            end
        end
        checks++;
        if (vr != 3 || pulses != 0) begin
            errors++; $display("FAIL stall_resume: got vrises=%0d pulses=%0d required 3 and 0", vr, pulses);
        end
    endtask

    task automatic test_mid_reset();
        int vr = 0, hr = 0, pulses = 0;
        for (int i = 0; i < 1000 && gen_line != 6; i++) cycle();
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL rst_precondition_lock: got %0d required 1", locked);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({pos_x, pos_y, in_display_area, line_len, frame_lines, locked, sync_error} !== 45'd0) begin
            errors++;
            $display("FAIL rst_async_clear: got x=%0d y=%0d len=%0d lines=%0d lock=%0d required all 0",
                     pos_x, pos_y, line_len, frame_lines, locked);
        end
        gen_en = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (2) cycle();
        restart_gen(0);
        for (int i = 0; i < 3000 && vr < 3; i++) begin
            cycle();
            if (sync_error) pulses++;
            if (h_rise_drv) begin
                hr++;
                if (hr >= 2) begin
                    checks++;
                    if (line_len !== LEN_NOM) begin
                        errors++; $display("FAIL rst_line_len: rise %0d got %0d required %0d", hr, line_len, LEN_NOM);
                    end
                end
            end
            if (v_rise_drv) begin
                vr++;
                checks++;
                if (locked !== (vr == 3)) begin
                    errors++; $display("FAIL rst_relock: vrise %0d got %0d required %0d", vr, locked, (vr == 3));
                end
            end
        end
        checks++;
        if (vr != 3 || pulses != 0) begin
            errors++; $display("FAIL rst_resume: got vrises=%0d pulses=%0d required 3 and 0", vr, pulses);
        end
    endtask

    task automatic test_coincident();
        int vr = 0, pulses = 0;
        for (int i = 0; i < 2000 && vr < 2; i++) begin
            cycle();
            if (sync_error) pulses++;
            if (v_rise_drv) begin
                vr++;
                checks++;
                if (pos_x !== X_EDGE || pos_y !== Y_EDGE) begin
                    errors++; $display("FAIL coin_reload: got x=%0d y=%0d required %0d %0d", pos_x, pos_y, X_EDGE, Y_EDGE);
                end
                checks++;
                if (frame_lines !== LINES_NOM) begin
                    errors++; $display("FAIL coin_frame_lines: got %0d required %0d", frame_lines, LINES_NOM);
                end
                checks++;
                if (locked !== 1'b1) begin
                    errors++; $display("FAIL coin_locked: got %0d required 1", locked);
                end
            end
        end
        checks++;
        if (vr != 2 || pulses != 0) begin
            errors++; $display("FAIL coin_stream: got vrises=%0d pulses=%0d required 2 and 0", vr, pulses);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_line();
        test_timeout();
        test_mid_reset();
        test_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
